// File: rtl/spi_sensor_pkg.sv
// Shared constants and FSM encoding for the SPI sensor slave and any matching master.
package spi_sensor_pkg;

  localparam int SPI_DATA_W     = 8;
  localparam int SPI_FRAME_BITS = 16;
  localparam int SPI_LEAD_ZEROS = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous input, plus a third flop for edge pulses.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic sync_p0, sync_p1, sync_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
      sync_p2 <= RST_VAL;
    end else begin
      sync_p0 <= async_in;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign lvl  = sync_p1;
  assign rise = sync_p1 & ~sync_p2;
  assign fall = ~sync_p1 & sync_p2;

endmodule

// File: rtl/spi_sensor_slave.sv
// SPI slave that streams one framed sensor sample per ss assertion, MSB first.
// Optional one-clk frame_err pulse on aborted frames: define SPI_SENSOR_SLAVE_ABORT_DETECT_EN.
module spi_sensor_slave
  import spi_sensor_pkg::*;
#(
  parameter int DATA_W     = SPI_DATA_W,
  parameter int FRAME_BITS = SPI_FRAME_BITS,
  parameter int LEAD_ZEROS = SPI_LEAD_ZEROS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              ss,
  output logic              miso,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(FRAME_BITS);

  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [DATA_W-1:0] s);
    logic [FRAME_BITS-1:0] f;
    f = '0;
    f[FRAME_BITS-1-LEAD_ZEROS -: DATA_W] = s;
    return f;
  endfunction

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ss_lvl, ss_rise, ss_fall;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .async_in(sclk),
    .lvl(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst(rst), .async_in(ss),
    .lvl(ss_lvl), .rise(ss_rise), .fall(ss_fall)
  );

  spi_state_e            state_q, state_d;
  logic [FRAME_BITS-1:0] shreg_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_W-1:0]     hold_q, last_q;
  logic                  hold_full_q;
  logic                  frame_done_q;
  logic [1:0]            settle_q;
  logic                  armed_q;

  logic                  do_load, do_shift, do_done, do_abort;
  logic                  accept;
  logic [DATA_W-1:0]     load_src;
  logic [FRAME_BITS-1:0] frame_ld;

  assign accept   = sample_valid & ~hold_full_q;
  assign load_src = hold_full_q ? hold_q : (accept ? sample : last_q);
  assign frame_ld = build_frame(load_src);

  always_comb begin
    state_d  = state_q;
    do_load  = 1'b0;
    do_shift = 1'b0;
    do_done  = 1'b0;
    do_abort = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ss_fall && armed_q) begin
          do_load = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ss_rise) begin
          do_abort = 1'b1;
          state_d  = ST_IDLE;
        end else if (!ss_lvl) begin
          if (sclk_rise && cnt_q == '0) begin
            do_done = 1'b1;
            state_d = ST_HOLD;
          end else if (sclk_fall && !sclk_lvl && cnt_q != '0) begin
            do_shift = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (ss_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame register: miso is its MSB, so the output is always a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      last_q       <= '0;
      frame_done_q <= 1'b0;
      settle_q     <= 2'd0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= do_done;
      // A low ss seen straight after reset must not start a frame; arm only
      // once the flushed synchronizer has shown ss idle high.
      if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
      if (settle_q == 2'd2 && ss_lvl) armed_q <= 1'b1;

      if (do_load) begin
        shreg_q <= frame_ld;
        cnt_q   <= CNT_W'(FRAME_BITS - 1);
        last_q  <= load_src;
      end else if (do_shift) begin
        shreg_q <= shreg_q << 1;
        cnt_q   <= cnt_q - 1'b1;
      end else if (do_done || do_abort) begin
        shreg_q <= '0;
      end

      if (do_load) begin
        hold_full_q <= 1'b0;
      end else if (accept) begin
        hold_q      <= sample;
        hold_full_q <= 1'b1;
      end
    end
  end

  assign miso         = shreg_q[FRAME_BITS-1];
  assign sample_ready = ~hold_full_q;
  assign frame_done   = frame_done_q;

`ifdef SPI_SENSOR_SLAVE_ABORT_DETECT_EN
  logic frame_err_q;

  always_ff @(posedge clk) begin
    if (rst) frame_err_q <= 1'b0;
    else     frame_err_q <= do_abort;
  end

  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: doc/spi_sensor_slave.md
SPI_SENSOR_SLAVE -- requirements
Module: spi_sensor_slave

Interface
REQ-001 Parameter DATA_W, default 8, sample width carried in each frame.
REQ-002 Parameter FRAME_BITS, default 16, number of SCLK cycles per frame.
REQ-003 Parameter LEAD_ZEROS, default 3, number of zero bits sent before the sample MSB.
REQ-004 clk  input  1  system clock; all logic is on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 sclk  input  1  SPI clock from the master; asynchronous to clk.
REQ-007 ss  input  1  active-low slave select from the master; asynchronous to clk.
REQ-008 miso  output  1  serial data to the master, MSB first.
REQ-009 sample  input  DATA_W  value to be sent in the next frame.
REQ-010 sample_valid  input  1  sample is valid.
REQ-011 sample_ready  output  1  holding register is empty and can accept a sample.
REQ-012 frame_done  output  1  one-clk pulse when all FRAME_BITS bits have been shifted.
REQ-013 frame_err  output  1  one-clk pulse when a frame is aborted (see REQ-027).

Function
REQ-014 sclk and ss each SHALL pass through a 2-flop synchronizer followed by an edge detector; all protocol decisions SHALL use the synchronized signals.
REQ-015 The frame SHALL be {LEAD_ZEROS zeros, sample MSB..LSB, FRAME_BITS-LEAD_ZEROS-DATA_W zeros}; with the defaults this is 3+8+5 bits.
REQ-016 Holding register: a sample SHALL be accepted on a clk where sample_valid and sample_ready are both high; sample_ready SHALL then go low on the next clk.
REQ-017 State machine states: IDLE, SHIFT, HOLD.
REQ-018 IDLE: miso SHALL be 0. On a synchronized ss falling edge, the FSM SHALL load the frame into the shift register, drive frame bit FRAME_BITS-1 on miso, set bit count = FRAME_BITS-1 and go to SHIFT.
REQ-019 Frame source at load: the holding register if it is full, which then empties and sets sample_ready=1; otherwise the last sent sample is repeated, and this is 0 after reset.
REQ-020 SHIFT: on each synchronized sclk falling edge, the FSM SHALL shift so that miso presents the next bit and SHALL decrement the count. The master samples on sclk rising edges.
REQ-021 SHIFT: on the sclk rising edge at which count==0, frame_done SHALL pulse for one clk and the FSM SHALL go to HOLD.
REQ-022 HOLD: miso SHALL be 0. Further sclk edges SHALL be ignored. On a synchronized ss rising edge the FSM SHALL return to IDLE.
REQ-023 miso SHALL change exactly 3 clk after the raw sclk or ss edge: 2 synchronizer stages plus 1 registered output.
REQ-024 clk frequency SHALL be at least 8x the sclk frequency. Behaviour below this ratio is undefined.
REQ-025 An sclk edge SHALL be ignored while synchronized ss is high.
REQ-026 Simultaneous accept (REQ-016) and frame load (REQ-019) in one clk: the load SHALL use the old holding content if full, or the incoming sample if empty. In either case the holding register SHALL end full only if a sample is left unconsumed.
REQ-027 A synchronized ss rising edge while in SHIFT SHALL abort the frame: FSM goes to IDLE, miso=0, no frame_done. frame_err SHALL pulse only per REQ-030.

Reset
REQ-028 While rst is high: FSM=IDLE, miso=0, sample_ready=1, frame_done=0, frame_err=0, holding register empty, last sample=0, count=0, synchronizer flops=1 (ss idle high) for ss and 0 for sclk.
REQ-029 rst asserted mid-frame SHALL take effect on the next clk. After release the block SHALL wait for a fresh ss falling edge, even if ss is still low.

Configuration
REQ-030 Macro SPI_SENSOR_SLAVE_ABORT_DETECT_EN. If defined, frame_err SHALL pulse for one clk on each abort per REQ-027. If undefined, frame_err SHALL be constant 0 and the abort-detect logic SHALL be absent. FSM abort behaviour SHALL be identical in both builds.

Structure
REQ-031 A shared package spi_sensor_pkg SHALL hold the FSM state encoding and the default constants DATA_W, FRAME_BITS and LEAD_ZEROS. The SPI master SHALL use the same constants.
REQ-032 A sub-module spi_sync_edge (2-flop synchronizer plus rise/fall pulse outputs, with reset value as a parameter) SHALL be instantiated once for sclk and once for ss.

Verification
REQ-033 Load sample=8'h0A, then a 16-cycle frame at clk/8 -> master captures 16'b000_00001010_00000, frame_done pulses once, sample_ready returns to 1.
REQ-034 Two back-to-back frames with no new sample between them -> the second frame repeats 8'h0A. Immediately after reset with no sample -> frame is 16'h0000.
REQ-035 ss raised after 6 sclk cycles -> no frame_done; frame_err pulses once only with the macro defined. The next full frame is correct.
REQ-036 sample_valid held high across an ss falling edge with the holding register full (8'h55 held, 8'hAA offered) -> frame sends 8'h55, 8'hAA is accepted into holding, and the next frame sends 8'hAA.
REQ-037 rst pulsed during bit 9 with ss still low -> miso=0, no output until ss rises and falls again. The following frame is correct.
REQ-038 Extra sclk pulses after bit 16 in HOLD -> miso stays 0, no second frame_done; measured edge-to-miso latency = 3 clk throughout.
